sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge_pkg.sv | 33 +++
 rtl/sram_axi_bridge_arb.sv | 18 +
 rtl/sram_axi_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and helpers for the SRAM-like to AXI bridge: FSM states,
// fixed AXI field values and the fixed-priority arbiter function.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE  = 3'd0;
    localparam int         ARB_MAXW       = 32;

    // SRAM size code 0/1/2 maps directly onto AXI AxSIZE 1/2/4 bytes
    function automatic logic [2:0] axi_size(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

    // Isolates the lowest set bit: lowest index wins
    function automatic logic [ARB_MAXW-1:0] prio_onehot(input logic [ARB_MAXW-1:0] req);
        return req & (~req + {{(ARB_MAXW-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/sram_axi_bridge_arb.sv
// Fixed-priority one-hot arbiter; bit 0 has the highest priority.
module prio_arb
    import sram_axi_bridge_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    logic [ARB_MAXW-1:0] gnt_wide_s;
    logic                unused_hi_s;

    assign gnt_wide_s  = prio_onehot(ARB_MAXW'(req_i));
    assign gnt_o       = gnt_wide_s[N-1:0];
    assign unused_hi_s = ^gnt_wide_s[ARB_MAXW-1:N];

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges NCH SRAM-like masters onto one AXI port, with one read and one
// write outstanding and a read-after-write word hazard stall.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int IDW = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [AW*NCH-1:0]     m_addr,
    input  logic [DW/8*NCH-1:0]   m_wstrb,
    input  logic [DW*NCH-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [DW-1:0]         m_rdata,
    output logic [IDW-1:0]        arid,
    output logic [AW-1:0]         araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [IDW-1:0]        rid,
    input  logic [DW-1:0]         rdata,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [IDW-1:0]        awid,
    output logic [AW-1:0]         awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DW-1:0]         wdata,
    output logic [DW/8-1:0]       wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [IDW-1:0]        bid,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int SW = DW / 8;

    logic [NCH-1:0]  rd_gnt_s, wr_gnt_s;
    logic [AW-1:0]   rd_addr_s, wr_addr_s;
    logic [1:0]      rd_size_s, wr_size_s;
    logic [IDW-1:0]  rd_id_s, wr_id_s;
    logic [SW-1:0]   wr_strb_s;
    logic [DW-1:0]   wr_data_s;
    logic            rd_acc_s, wr_acc_s, hazard_s, rd_done_s, wr_done_s;
    logic            aw_pend_s, w_pend_s, unused_s;

    rd_state_e       rd_st_q;
    wr_state_e       wr_st_q;
    logic            arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [AW-1:0]   araddr_q, awaddr_q;
    logic [2:0]      arsize_q, awsize_q;
    logic [IDW-1:0]  arid_q, awid_q;
    logic [SW-1:0]   wstrb_q;
    logic [DW-1:0]   wdata_q;
    logic [NCH-1:0]  rd_own_q, wr_own_q;

    prio_arb #(.N(NCH)) u_rd_arb (.req_i(m_req & ~m_wr), .gnt_o(rd_gnt_s));
    prio_arb #(.N(NCH)) u_wr_arb (.req_i(m_req & m_wr),  .gnt_o(wr_gnt_s));

    // One-hot grant muxes for the selected read and write request fields
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        rd_size_s = 2'b00;
        rd_id_s   = {IDW{1'b0}};
        wr_addr_s = {AW{1'b0}};
        wr_size_s = 2'b00;
        wr_id_s   = {IDW{1'b0}};
        wr_strb_s = {SW{1'b0}};
        wr_data_s = {DW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            rd_addr_s |= {AW{rd_gnt_s[i]}} & m_addr[i*AW +: AW];
            rd_size_s |= {2{rd_gnt_s[i]}} & m_size[2*i +: 2];
            rd_id_s   |= rd_gnt_s[i] ? IDW'(i) : {IDW{1'b0}};
            wr_addr_s |= {AW{wr_gnt_s[i]}} & m_addr[i*AW +: AW];
            wr_size_s |= {2{wr_gnt_s[i]}} & m_size[2*i +: 2];
            wr_id_s   |= wr_gnt_s[i] ? IDW'(i) : {IDW{1'b0}};
            wr_strb_s |= {SW{wr_gnt_s[i]}} & m_wstrb[i*SW +: SW];
            wr_data_s |= {DW{wr_gnt_s[i]}} & m_wdata[i*DW +: DW];
        end
    end

    assign wr_acc_s = resetn && (wr_st_q == W_IDLE) && (|wr_gnt_s);
    // A read may not overtake a write to the same word, including one accepted now
    assign hazard_s = ((wr_st_q != W_IDLE) && (rd_addr_s[AW-1:2] == awaddr_q[AW-1:2])) ||
                      (wr_acc_s && (rd_addr_s[AW-1:2] == wr_addr_s[AW-1:2]));
    assign rd_acc_s = resetn && (rd_st_q == R_IDLE) && (|rd_gnt_s) && !hazard_s;

    assign rd_done_s = rready_q && rvalid && rlast;
    assign wr_done_s = bready_q && bvalid;
    assign aw_pend_s = awvalid_q && !awready;
    assign w_pend_s  = wvalid_q && !wready;

    assign m_addr_ok = ({NCH{rd_acc_s}} & rd_gnt_s) | ({NCH{wr_acc_s}} & wr_gnt_s);
    assign m_data_ok = ({NCH{rd_done_s}} & rd_own_q) | ({NCH{wr_done_s}} & wr_own_q);
    assign m_rdata   = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awid    = awid_q;
    assign awaddr  = awaddr_q;
    assign awsize  = awsize_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign unused_s = ^{rid, bid};

    // Read FSM: accept, issue AR, wait for the single R beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_st_q   <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= {AW{1'b0}};
            arsize_q  <= 3'd0;
            arid_q    <= {IDW{1'b0}};
            rd_own_q  <= {NCH{1'b0}};
        end else begin
            case (rd_st_q)
                R_IDLE: if (rd_acc_s) begin
                    rd_st_q   <= R_AR;
                    arvalid_q <= 1'b1;
                    araddr_q  <= rd_addr_s;
                    arsize_q  <= axi_size(rd_size_s);
                    arid_q    <= rd_id_s;
                    rd_own_q  <= rd_gnt_s;
                end
                R_AR: if (arready) begin
                    rd_st_q   <= R_R;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                end
                R_R: if (rd_done_s) begin
                    rd_st_q  <= R_IDLE;
                    rready_q <= 1'b0;
                end
                default: begin
                    rd_st_q   <= R_IDLE;
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: AW and W complete independently before waiting on B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_st_q   <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= {AW{1'b0}};
            awsize_q  <= 3'd0;
            awid_q    <= {IDW{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            wr_own_q  <= {NCH{1'b0}};
        end else begin
            case (wr_st_q)
                W_IDLE: if (wr_acc_s) begin
                    wr_st_q   <= W_REQ;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    awaddr_q  <= wr_addr_s;
                    awsize_q  <= axi_size(wr_size_s);
                    awid_q    <= wr_id_s;
                    wstrb_q   <= wr_strb_s;
                    wdata_q   <= wr_data_s;
                    wr_own_q  <= wr_gnt_s;
                end
                W_REQ: begin
                    if (awvalid_q && awready) awvalid_q <= 1'b0;
                    if (wvalid_q && wready)   wvalid_q  <= 1'b0;
                    if (!aw_pend_s && !w_pend_s) begin
                        wr_st_q  <= W_B;
                        bready_q <= 1'b1;
                    end
                end
                W_B: if (wr_done_s) begin
                    wr_st_q  <= W_IDLE;
                    bready_q <= 1'b0;
                end
                default: begin
                    wr_st_q   <= W_IDLE;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: two SRAM-like masters, a reactive
// AXI slave and a rule-level model of grant, hazard and completion.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_req, m_wr, m_addr_ok, m_data_ok;
    logic [3:0]  m_size;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_bridge #(.NCH(2), .AW(32), .DW(32), .IDW(4)) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
    } done_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    cmd_t  cmd_q [2][$];
    cmd_t  cur [2];
    int    dst [2];
    int    wait_cnt [2];
    int    acc_cyc [2];
    int    done_cyc [2];
    int    rand_left [2];
    xfer_t ar_q[$], aw_q[$], w_q[$];
    done_t done_q [2][$];
    int    aw_seen = 0, w_seen = 0;
    int    dir_rd_delay = -1, dir_aw_stall = -1, dir_w_stall = -1, dir_b_delay = -1;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Slave read data is a fixed scramble of the address
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic cmd_t mk(input bit wr, input logic [31:0] a, input logic [1:0] s,
                                input logic [3:0] st, input logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.size = s; c.strb = st; c.data = d;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr   = 1'($urandom_range(0, 1));
        c.size = 2'($urandom_range(0, 2));
        c.addr = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
        if (c.size == 2'd1) c.addr += 32'($urandom_range(0, 1)) * 32'd2;
        else if (c.size == 2'd0) c.addr += 32'($urandom_range(0, 3));
        c.strb = 4'($urandom);
        c.data = $urandom;
        return c;
    endfunction

    // Master driver: one outstanding transaction per channel
    initial begin
        m_req = 2'b00; m_wr = 2'b00; m_size = 4'd0; m_addr = 64'd0;
        m_wstrb = 8'd0; m_wdata = 64'd0;
        for (int c = 0; c < 2; c++) begin
            dst[c] = 0; wait_cnt[c] = 0; acc_cyc[c] = 0; done_cyc[c] = 0; rand_left[c] = 0;
            cur[c] = mk(1'b0, 32'd0, 2'd0, 4'd0, 32'd0);
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < 2; c++) begin
                if (!resetn) dst[c] = 0;
                else if (dst[c] == 1 && m_addr_ok[c]) begin dst[c] = 2; acc_cyc[c] = cyc; wait_cnt[c] = 0; end
                else if (dst[c] == 2 && m_data_ok[c]) begin dst[c] = 0; done_cyc[c] = cyc; end
                else if (dst[c] != 0) begin
                    wait_cnt[c]++;
                    if (wait_cnt[c] > 200) begin
                        check(1'b0, "master_timeout", 64'(c), 64'(dst[c]));
                        dst[c] = 0;
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (dst[c] == 0 && resetn) begin
                    if (cmd_q[c].size() > 0) begin cur[c] = cmd_q[c].pop_front(); dst[c] = 1; wait_cnt[c] = 0; end
                    else if (rand_left[c] > 0 && $urandom_range(0, 2) == 0) begin
                        cur[c] = rand_cmd(); rand_left[c]--; dst[c] = 1; wait_cnt[c] = 0;
                    end
                end
                m_req[c]          = (dst[c] == 1);
                m_wr[c]           = cur[c].wr;
                m_size[2*c +: 2]  = cur[c].size;
                m_addr[32*c +: 32] = cur[c].addr;
                m_wstrb[4*c +: 4]  = cur[c].strb;
                m_wdata[32*c +: 32] = cur[c].data;
            end
        end
    end

    // AXI slave: random or directed ready/response delays
    initial begin
        bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got;
        logic [31:0] s_araddr, rd_a;
        logic [3:0]  s_arid, s_awid, rd_id, b_id;
        int          rd_cnt, aw_cnt, w_cnt, b_cnt;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rid = 4'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; rd_a = 32'd0; rd_id = 4'd0; b_id = 4'd0;
        rd_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            s_araddr = araddr; s_arid = arid; s_awid = awid;
            @(posedge clk);
            #1;
            if (!resetn) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            end else begin
                if (r_hs) begin rvalid = 1'b0; rlast = 1'b0; rd_pend = 1'b0; end
                if (ar_hs) begin
                    arready = 1'b0; rd_pend = 1'b1; rd_a = s_araddr; rd_id = s_arid;
                    rd_cnt = (dir_rd_delay >= 0) ? dir_rd_delay : $urandom_range(0, 3);
                end else if (!rd_pend) arready = ($urandom_range(0, 1) == 1);
                else if (!rvalid) begin
                    if (rd_cnt == 0) begin rvalid = 1'b1; rlast = 1'b1; rdata = pat(rd_a); rid = rd_id; end
                    else rd_cnt--;
                end
                if (b_hs) begin bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
                if (aw_hs) begin
                    awready = 1'b0; aw_got = 1'b1; b_id = s_awid;
                    b_cnt = (dir_b_delay >= 0) ? dir_b_delay : $urandom_range(0, 3);
                end else if (!aw_got && !awvalid) aw_cnt = (dir_aw_stall >= 0) ? dir_aw_stall : $urandom_range(0, 3);
                else if (!aw_got) begin if (aw_cnt == 0) awready = 1'b1; else aw_cnt--; end
                if (w_hs) begin wready = 1'b0; w_got = 1'b1; end
                else if (!w_got && !wvalid) w_cnt = (dir_w_stall >= 0) ? dir_w_stall : $urandom_range(0, 3);
                else if (!w_got) begin if (w_cnt == 0) wready = 1'b1; else w_cnt--; end
                if (aw_got && w_got && !bvalid && !b_hs) begin
                    if (b_cnt == 0) begin bvalid = 1'b1; bid = b_id; end
                    else b_cnt--;
                end
            end
        end
    end

    // Reference model and scoreboard monitor
    initial begin
        bit          rd_busy, wr_busy, haz, wr_take;
        logic [31:0] wr_a, ra;
        logic [1:0]  exp_ok;
        int          wc, rc;
        xfer_t       x;
        done_t       d;
        rd_busy = 1'b0; wr_busy = 1'b0; wr_a = 32'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check(m_addr_ok == 2'b00 && m_data_ok == 2'b00, "ok_in_reset", {m_addr_ok, m_data_ok}, 64'd0);
                rd_busy = 1'b0; wr_busy = 1'b0;
                ar_q.delete(); aw_q.delete(); w_q.delete(); done_q[0].delete(); done_q[1].delete();
            end else begin
                wc = -1; rc = -1;
                for (int c = 1; c >= 0; c--) begin
                    if (m_req[c] && m_wr[c]) wc = c;
                    if (m_req[c] && !m_wr[c]) rc = c;
                end
                exp_ok = 2'b00;
                wr_take = (wc >= 0) && !wr_busy;
                if (wr_take) exp_ok[wc] = 1'b1;
                if (rc >= 0 && !rd_busy) begin
                    ra = m_addr[32*rc +: 32];
                    haz = wr_busy && (ra[31:2] == wr_a[31:2]);
                    if (wr_take) haz = haz || (ra[31:2] == m_addr[32*wc+2 +: 30]);
                    if (!haz) exp_ok[rc] = 1'b1;
                end
                check(m_addr_ok == exp_ok, "addr_ok", 64'(m_addr_ok), 64'(exp_ok));
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) check(1'b0, "ar_unexpected", 64'(araddr), 64'd0);
                    else begin
                        x = ar_q.pop_front();
                        check(araddr == x.addr, "araddr", 64'(araddr), 64'(x.addr));
                        check(arid == 4'(x.ch), "arid", 64'(arid), 64'(x.ch));
                        check(arsize == {1'b0, x.size}, "arsize", 64'(arsize), 64'(x.size));
                    end
                end
                if (awvalid && awready) begin
                    aw_seen++;
                    if (aw_q.size() == 0) check(1'b0, "aw_unexpected", 64'(awaddr), 64'd0);
                    else begin
                        x = aw_q.pop_front();
                        check(awaddr == x.addr, "awaddr", 64'(awaddr), 64'(x.addr));
                        check(awid == 4'(x.ch), "awid", 64'(awid), 64'(x.ch));
                        check(awsize == {1'b0, x.size}, "awsize", 64'(awsize), 64'(x.size));
                    end
                end
                if (wvalid && wready) begin
                    w_seen++;
                    if (w_q.size() == 0) check(1'b0, "w_unexpected", 64'(wdata), 64'd0);
                    else begin
                        x = w_q.pop_front();
                        check(wdata == x.data, "wdata", 64'(wdata), 64'(x.data));
                        check(wstrb == x.strb, "wstrb", 64'(wstrb), 64'(x.strb));
                        check(wlast == 1'b1, "wlast", 64'(wlast), 64'd1);
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (m_data_ok[c]) begin
                        if (done_q[c].size() == 0) check(1'b0, "data_ok_unexpected", 64'(c), 64'd0);
                        else begin
                            d = done_q[c].pop_front();
                            if (d.wr) wr_busy = 1'b0;
                            else begin
                                rd_busy = 1'b0;
                                check(m_rdata == d.rdata, "m_rdata", 64'(m_rdata), 64'(d.rdata));
                            end
                        end
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (m_addr_ok[c] && m_req[c]) begin
                        x.ch = c; x.addr = m_addr[32*c +: 32]; x.size = m_size[2*c +: 2];
                        x.strb = m_wstrb[4*c +: 4]; x.data = m_wdata[32*c +: 32];
                        d.wr = m_wr[c]; d.rdata = pat(x.addr);
                        done_q[c].push_back(d);
                        if (m_wr[c]) begin wr_busy = 1'b1; wr_a = x.addr; aw_q.push_back(x); w_q.push_back(x); end
                        else begin rd_busy = 1'b1; ar_q.push_back(x); end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            #1;
            idle = (dst[0] == 0) && (dst[1] == 0) && (cmd_q[0].size() == 0) && (cmd_q[1].size() == 0) &&
                   (rand_left[0] == 0) && (rand_left[1] == 0);
        end
        check(idle, "wait_idle", 64'(idle), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check(arvalid == 1'b0 && rready == 1'b0, {tag, "_rd_hs"}, {arvalid, rready}, 64'd0);
        check(awvalid == 1'b0 && wvalid == 1'b0 && bready == 1'b0, {tag, "_wr_hs"}, {awvalid, wvalid, bready}, 64'd0);
        check(m_addr_ok == 2'b00 && m_data_ok == 2'b00, {tag, "_ok"}, {m_addr_ok, m_data_ok}, 64'd0);
        check(arid == 4'd0 && awid == 4'd0, {tag, "_ids"}, {arid, awid}, 64'd0);
        check(araddr == 32'd0 && awaddr == 32'd0, {tag, "_addr"}, {araddr, awaddr}, 64'd0);
    endtask

    initial begin
        int aw0, w0;
        bit seen;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // ch1 read with a 2-cycle slave response
        dir_rd_delay = 2;
        cmd_q[1].push_back(mk(1'b0, 32'h1fc0_0000, 2'd2, 4'hf, 32'd0));
        wait_idle(100);
        check(done_cyc[1] > acc_cyc[1] && acc_cyc[1] > 0, "ch1_read_done", 64'(done_cyc[1]), 64'(acc_cyc[1]));
        dir_rd_delay = -1;

        // simultaneous reads: ch0 first
        cmd_q[0].push_back(mk(1'b0, 32'h200, 2'd2, 4'hf, 32'd0));
        cmd_q[1].push_back(mk(1'b0, 32'h300, 2'd2, 4'hf, 32'd0));
        wait_idle(100);
        check(acc_cyc[1] > done_cyc[0], "read_priority", 64'(acc_cyc[1]), 64'(done_cyc[0]));

        // wready two cycles ahead of awready
        dir_aw_stall = 2; dir_w_stall = 0;
        aw0 = aw_seen; w0 = w_seen;
        cmd_q[1].push_back(mk(1'b1, 32'h8000_0010, 2'd2, 4'b0011, 32'hcafe_f00d));
        wait_idle(100);
        check(aw_seen - aw0 == 1, "single_aw", 64'(aw_seen - aw0), 64'd1);
        check(w_seen - w0 == 1, "single_w", 64'(w_seen - w0), 64'd1);
        dir_aw_stall = -1; dir_w_stall = -1;

        // read of the same word as a pending write is held
        dir_b_delay = 6;
        cmd_q[0].push_back(mk(1'b1, 32'h100, 2'd2, 4'hf, 32'h1234_5678));
        cmd_q[1].push_back(mk(1'b0, 32'h102, 2'd1, 4'h0, 32'd0));
        wait_idle(100);
        check(acc_cyc[1] > done_cyc[0], "hazard_hold", 64'(acc_cyc[1]), 64'(done_cyc[0]));
        cmd_q[0].push_back(mk(1'b1, 32'h100, 2'd2, 4'hf, 32'h8765_4321));
        cmd_q[1].push_back(mk(1'b0, 32'h104, 2'd2, 4'h0, 32'd0));
        wait_idle(100);
        check(acc_cyc[1] == acc_cyc[0], "no_hazard_same_cycle", 64'(acc_cyc[1]), 64'(acc_cyc[0]));
        dir_b_delay = -1;

        // reset while waiting for R
        dir_rd_delay = 8;
        cmd_q[0].push_back(mk(1'b0, 32'h40, 2'd2, 4'h0, 32'd0));
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rready;
        end
        check(seen, "reach_rready", 64'(seen), 64'd1);
        #2 resetn = 1'b0;
        #1 check_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        dir_rd_delay = -1;
        cmd_q[0].push_back(mk(1'b0, 32'h44, 2'd2, 4'h0, 32'd0));
        wait_idle(100);
        check(done_cyc[0] > acc_cyc[0], "read_after_reset", 64'(done_cyc[0]), 64'(acc_cyc[0]));

        // randomized traffic on both channels
        rand_left[0] = 60; rand_left[1] = 60;
        wait_idle(8000);
        check(ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0, "drain_axi",
              64'(ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
        check(done_q[0].size() == 0 && done_q[1].size() == 0, "drain_done",
              64'(done_q[0].size() + done_q[1].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
